instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 113 +++++++++++
 tb/tb_instruction_fetch.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch stage: issues word-aligned reads at the PC,
// registers returned words for decode, and squashes stale responses after a redirect.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [0:0] {
    StReq,
    StWait
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        discard_q, discard_d;

  logic [31:0] redirect_target;
  logic        req_fire;

  // Masking keeps every redirect_pc bit in use while forcing word alignment.
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  // A new request only goes out when the output register is free or draining this cycle.
  assign imem_req_valid = !rst && (state_q == StReq) && !redirect_valid &&
                          (!instr_valid_q || instr_ready);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign instruction = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    discard_d     = discard_q;
    instr_valid_d = instr_valid_q && !instr_ready;

    unique case (state_q)
      StReq: begin
        if (redirect_valid) begin
          pc_d          = redirect_target;
          instr_valid_d = 1'b0;
        end else if (req_fire) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (redirect_valid) begin
          pc_d          = redirect_target;
          instr_valid_d = 1'b0;
          if (imem_resp_valid) begin
            // The in-flight response is the one being squashed, so nothing stays stale.
            state_d   = StReq;
            discard_d = 1'b0;
          end else begin
            discard_d = 1'b1;
          end
        end else if (imem_resp_valid) begin
          state_d = StReq;
          if (discard_q) begin
            discard_d = 1'b0;
          end else begin
            instr_d       = imem_resp_data;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + 32'd4;
          end
        end
      end
      default: state_d = StReq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StReq;
      pc_q          <= RESET_PC;
      instr_q       <= Nop;
      instr_pc_q    <= 32'h0000_0000;
      instr_valid_q <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      discard_q     <= discard_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized and directed checks of instruction_fetch against a transaction-level model
// that tracks the fetch PC, the outstanding read and whether it has been squashed.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst, redirect_valid, imem_req_ready, imem_resp_valid, instr_ready;
  logic [31:0] redirect_pc, imem_resp_data;
  logic        imem_req_valid, instr_valid;
  logic [31:0] imem_req_addr, instruction, instr_pc;

  logic        w_rst, w_redirect_valid, w_req_ready, w_resp_valid, w_instr_ready;
  logic [31:0] w_redirect_pc, w_resp_data;
  logic        w_req_valid, w_instr_valid;
  logic [31:0] w_req_addr, w_instruction, w_instr_pc;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk            (clk),
    .rst            (w_rst),
    .redirect_valid (w_redirect_valid),
    .redirect_pc    (w_redirect_pc),
    .imem_req_valid (w_req_valid),
    .imem_req_addr  (w_req_addr),
    .imem_req_ready (w_req_ready),
    .imem_resp_valid(w_resp_valid),
    .imem_resp_data (w_resp_data),
    .instruction    (w_instruction),
    .instr_pc       (w_instr_pc),
    .instr_valid    (w_instr_valid),
    .instr_ready    (w_instr_ready)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state: fetch PC, read in flight, read squashed, decode register.
  logic [31:0] m_pc, m_instr, m_ipc;
  logic        m_out, m_stale, m_valid;
  // Memory model: one pending read with a countdown.
  logic        mem_pend;
  int unsigned mem_cnt;
  logic [31:0] mem_addr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    m_pc    = 32'h0;
    m_instr = 32'h0000_0013;
    m_ipc   = 32'h0;
    m_out   = 1'b0;
    m_stale = 1'b0;
    m_valid = 1'b0;
  endtask

  // One clock cycle: drive inputs, check every output against the model, advance the model.
  task automatic cycle(input logic r, input logic rv, input logic [31:0] rpc,
                       input logic mrdy, input logic rspv, input logic [31:0] rspd,
                       input logic irdy, output logic fire, output logic [31:0] fire_addr,
                       output logic obs_v, output logic [31:0] obs_a);
    logic exp_req, nv;
    @(negedge clk);
    rst             = r;
    redirect_valid  = rv;
    redirect_pc     = rpc;
    imem_req_ready  = mrdy;
    imem_resp_valid = rspv;
    imem_resp_data  = rspd;
    instr_ready     = irdy;
    #1;
    exp_req = !r && !m_out && !rv && (!m_valid || irdy);
    obs_v   = imem_req_valid;
    obs_a   = imem_req_addr;
    check_eq("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
    if (exp_req) check_eq("req_addr", imem_req_addr, m_pc);
    check_eq("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
    check_eq("instruction", instruction, m_instr);
    check_eq("instr_pc", instr_pc, m_ipc);
    fire      = exp_req && mrdy;
    fire_addr = m_pc;
    if (r) begin
      model_reset();
    end else begin
      nv = m_valid && !irdy;
      if (m_out && rspv) begin
        m_out = 1'b0;
        if (!rv && !m_stale) begin
          m_instr = rspd;
          m_ipc   = m_pc;
          m_pc    = m_pc + 32'd4;
          nv      = 1'b1;
        end
        m_stale = 1'b0;
      end else if (m_out && rv) begin
        m_stale = 1'b1;
      end
      if (fire) m_out = 1'b1;
      if (rv) begin
        m_pc = {rpc[31:2], 2'b00};
        nv   = 1'b0;
      end
      m_valid = nv;
    end
    @(posedge clk);
  endtask

  logic        f, ov, r, rv, mrdy, rspv, irdy;
  logic [31:0] fa, oa, rpc, rspd;

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0; instr_ready = 1'b0;
    w_rst = 1'b1; w_redirect_valid = 1'b0; w_redirect_pc = '0; w_req_ready = 1'b0;
    w_resp_valid = 1'b0; w_resp_data = '0; w_instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    mem_pend = 1'b0; mem_cnt = 0; mem_addr = '0;

    // Reset state, then first fetch with a 1-cycle response.
    cycle(1, 0, 0, 0, 0, 0, 1, f, fa, ov, oa);
    check_eq("rst_req_valid", {31'b0, ov}, 32'd0);
    cycle(0, 0, 0, 1, 0, 0, 1, f, fa, ov, oa);
    check_eq("first_req_valid", {31'b0, ov}, 32'd1);
    check_eq("first_req_addr", oa, 32'h0);
    cycle(0, 0, 0, 1, 1, 32'h0050_0093, 1, f, fa, ov, oa);
    check_eq("wait_no_req", {31'b0, ov}, 32'd0);
    #1;
    check_eq("first_instr", instruction, 32'h0050_0093);
    check_eq("first_instr_pc", instr_pc, 32'h0);
    check_eq("first_valid", {31'b0, instr_valid}, 32'd1);

    // Decode stalled: no request; on release the next request issues immediately.
    repeat (5) begin
      cycle(0, 0, 0, 1, 0, 0, 0, f, fa, ov, oa);
      check_eq("stall_no_req", {31'b0, ov}, 32'd0);
    end
    cycle(0, 0, 0, 1, 0, 0, 1, f, fa, ov, oa);
    check_eq("unstall_req_valid", {31'b0, ov}, 32'd1);
    check_eq("unstall_req_addr", oa, 32'h4);

    // Redirect while waiting; the stale response that follows is dropped.
    cycle(0, 1, 32'h0000_0103, 1, 0, 0, 1, f, fa, ov, oa);
    cycle(0, 0, 0, 1, 1, 32'hDEAD_BEEF, 1, f, fa, ov, oa);
    check_eq("stale_no_req", {31'b0, ov}, 32'd0);
    #1;
    check_eq("stale_dropped", {31'b0, instr_valid}, 32'd0);
    cycle(0, 0, 0, 1, 0, 0, 1, f, fa, ov, oa);
    check_eq("redir_req_valid", {31'b0, ov}, 32'd1);
    check_eq("redir_req_addr", oa, 32'h0000_0100);

    // Redirect coinciding with the response: no residual discard.
    cycle(0, 1, 32'h0000_0200, 1, 1, 32'h1234_5678, 1, f, fa, ov, oa);
    cycle(0, 0, 0, 1, 0, 0, 1, f, fa, ov, oa);
    check_eq("coinc_req_addr", oa, 32'h0000_0200);
    cycle(0, 0, 0, 0, 1, 32'h1111_1111, 0, f, fa, ov, oa);
    #1;
    check_eq("coinc_instr", instruction, 32'h1111_1111);
    check_eq("coinc_instr_pc", instr_pc, 32'h0000_0200);

    // Reset while holding a valid instruction, and reset while waiting.
    cycle(1, 0, 0, 0, 0, 0, 0, f, fa, ov, oa);
    #1;
    check_eq("rst_valid_clr", {31'b0, instr_valid}, 32'd0);
    check_eq("rst_nop", instruction, 32'h0000_0013);
    cycle(0, 0, 0, 1, 0, 0, 1, f, fa, ov, oa);
    check_eq("rel_req_addr", oa, 32'h0);
    cycle(1, 0, 0, 0, 0, 0, 1, f, fa, ov, oa);
    cycle(1, 0, 0, 0, 0, 0, 1, f, fa, ov, oa);
    check_eq("rst_wait_no_req", {31'b0, ov}, 32'd0);
    cycle(0, 0, 0, 0, 0, 0, 1, f, fa, ov, oa);
    check_eq("rel2_req_valid", {31'b0, ov}, 32'd1);
    check_eq("rel2_req_addr", oa, 32'h0);

    // Randomized traffic with variable memory latency, stalls, redirects and resets.
    for (int i = 0; i < 4000; i++) begin
      r    = (i == 0) || ($urandom_range(0, 199) == 0);
      rv   = ($urandom_range(0, 9) == 0);
      rpc  = $urandom;
      mrdy = ($urandom_range(0, 9) < 7);
      irdy = ($urandom_range(0, 9) < 7);
      rspv = 1'b0;
      rspd = $urandom;
      if (!r && mem_pend && mem_cnt == 0) begin
        rspv = 1'b1;
        rspd = mem_word(mem_addr);
      end
      cycle(r, rv, rpc, mrdy, rspv, rspd, irdy, f, fa, ov, oa);
      if (r) begin
        mem_pend = 1'b0;
      end else begin
        if (rspv) mem_pend = 1'b0;
        else if (mem_pend) mem_cnt--;
        if (f) begin
          mem_pend = 1'b1;
          mem_cnt  = $urandom_range(0, 2);
          mem_addr = fa;
        end
      end
    end

    // PC wrap from the top of the address space.
    @(negedge clk);
    rst = 1'b1;
    w_rst = 1'b0; w_req_ready = 1'b1; w_instr_ready = 1'b1;
    #1;
    check_eq("wrap_req_valid", {31'b0, w_req_valid}, 32'd1);
    check_eq("wrap_req_addr", w_req_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    w_req_ready = 1'b0; w_resp_valid = 1'b1; w_resp_data = 32'hCAFE_0013;
    @(negedge clk);
    w_resp_valid = 1'b0; w_req_ready = 1'b1;
    #1;
    check_eq("wrap_instr_pc", w_instr_pc, 32'hFFFF_FFFC);
    check_eq("wrap_instr", w_instruction, 32'hCAFE_0013);
    check_eq("wrap_next_addr", w_req_addr, 32'h0000_0000);
    check_eq("wrap_next_valid", {31'b0, w_req_valid}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
